// File: rtl/fpu_round_pkg.sv
// Shared types and constants for the FP32 rounding-stage front end:
// field widths, rounding-mode encodings, GRS bit positions and the response record.
package fpu_round_pkg;

  localparam int FP32_W = 32;
  localparam int EXP_W  = 8;
  localparam int MAN_W  = 23;
  localparam int RM_W   = 3;
  localparam int GRS_W  = 3;

  typedef enum logic [2:0] {
    RM_RNE = 3'd0,
    RM_RTZ = 3'd1,
    RM_RDN = 3'd2,
    RM_RUP = 3'd3,
    RM_RMM = 3'd4
  } rmode_e;

  localparam int GRS_G = 2;
  localparam int GRS_R = 1;
  localparam int GRS_S = 0;

  // Response record is sized for the largest supported configuration
  // (8 requesters, 16-bit tags); narrower instances use the low bits.
  localparam int SRC_W_MAX = 3;
  localparam int TAG_W_MAX = 16;

  typedef struct packed {
    logic [FP32_W-1:0]    data;
    logic [SRC_W_MAX-1:0] src;
    logic [TAG_W_MAX-1:0] tag;
    logic                 inexact;
    logic                 rm_err;
  } rsp_t;

  function automatic logic rm_reserved(input logic [RM_W-1:0] rm);
    return rm > 3'(RM_RMM);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: combinational search from a rotating pointer.
// The pointer moves past the winner only when the grant is actually taken (en).
module rr_arbiter #(
  parameter int N = 3
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [N-1:0]         req,
  input  logic                 en,
  output logic [N-1:0]         gnt,
  output logic [$clog2(N)-1:0] gnt_idx
);

  localparam int IDX_W = $clog2(N);

  logic [IDX_W-1:0] ptr_reg;
  logic [IDX_W-1:0] ptr_next;
  logic [IDX_W-1:0] cand;
  logic             found;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    cand    = '0;
    for (int k = 0; k < N; k++) begin
      cand = IDX_W'((32'(ptr_reg) + 32'(k)) % 32'(N));
      if (!found && req[cand]) begin
        found        = 1'b1;
        gnt[cand]    = 1'b1;
        gnt_idx      = cand;
      end
    end
  end

  assign ptr_next = (gnt_idx == IDX_W'(N - 1)) ? '0 : gnt_idx + IDX_W'(1);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_reg <= '0;
    end else if (en && found) begin
      ptr_reg <= ptr_next;
    end
  end

endmodule

// File: rtl/round_arbiter.sv
// Shares one FP32 rounding stage among NUM_REQ requesters, one op per cycle,
// and returns results in issue order through a 2-entry credit-controlled buffer.
module round_arbiter
  import fpu_round_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int TAG_W   = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic [NUM_REQ-1:0]         req_valid_i,
  output logic [NUM_REQ-1:0]         req_ready_o,
  input  logic [NUM_REQ*32-1:0]      req_data_i,
  input  logic [NUM_REQ*3-1:0]       req_rmode_i,
  input  logic [NUM_REQ*3-1:0]       req_grs_i,
  input  logic [NUM_REQ*TAG_W-1:0]   req_tag_i,
  output logic [31:0]                rnd_data_o,
  output logic [2:0]                 rnd_rmode_o,
  output logic [2:0]                 rnd_grs_o,
  input  logic [31:0]                rnd_data_i,
  output logic                       rsp_valid_o,
  input  logic                       rsp_ready_i,
  output logic [31:0]                rsp_data_o,
  output logic [$clog2(NUM_REQ)-1:0] rsp_src_o,
  output logic [TAG_W-1:0]           rsp_tag_o,
  output logic                       rsp_inexact_o,
  output logic                       rsp_rm_err_o
);

  localparam int SRC_W = $clog2(NUM_REQ);

  logic [FP32_W-1:0] data_arr  [NUM_REQ];
  logic [RM_W-1:0]   rmode_arr [NUM_REQ];
  logic [GRS_W-1:0]  grs_arr   [NUM_REQ];
  logic [TAG_W-1:0]  tag_arr   [NUM_REQ];

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign data_arr[gi]  = req_data_i[gi*FP32_W +: FP32_W];
    assign rmode_arr[gi] = req_rmode_i[gi*RM_W +: RM_W];
    assign grs_arr[gi]   = req_grs_i[gi*GRS_W +: GRS_W];
    assign tag_arr[gi]   = req_tag_i[gi*TAG_W +: TAG_W];
  end

  logic [NUM_REQ-1:0] gnt;
  logic [SRC_W-1:0]   gnt_idx;
  logic               gnt_any;
  logic               can_issue;
  logic               issue;
  logic               push;
  logic               pop;

  logic               inflight_valid_reg;
  rsp_t               inflight_reg;
  rsp_t               push_entry;
  rsp_t               head;
  rsp_t               fifo_mem [2];
  logic               wr_ptr_reg;
  logic               rd_ptr_reg;
  logic [1:0]         occ_reg;

  logic [FP32_W-1:0]  rnd_data_reg;
  logic [RM_W-1:0]    rnd_rmode_reg;
  logic [GRS_W-1:0]   rnd_grs_reg;

  // Two credits shared by buffered results and the op inside the rounding stage;
  // a pop in the same cycle frees one. Reset forces everything idle immediately.
  assign pop       = rsp_valid_o & rsp_ready_i;
  assign can_issue = rst_ni & (((occ_reg + {1'b0, inflight_valid_reg}) < 2'd2) | pop);

  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .req     (req_valid_i),
    .en      (can_issue),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  assign gnt_any     = rst_ni & (|gnt);
  assign req_ready_o = gnt & {NUM_REQ{can_issue}};
  assign issue       = |req_ready_o;

  assign rnd_data_o  = gnt_any ? data_arr[gnt_idx]  : rnd_data_reg;
  assign rnd_rmode_o = gnt_any ? rmode_arr[gnt_idx] : rnd_rmode_reg;
  assign rnd_grs_o   = gnt_any ? grs_arr[gnt_idx]   : rnd_grs_reg;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rnd_data_reg  <= '0;
      rnd_rmode_reg <= '0;
      rnd_grs_reg   <= '0;
    end else if (gnt_any) begin
      rnd_data_reg  <= data_arr[gnt_idx];
      rnd_rmode_reg <= rmode_arr[gnt_idx];
      rnd_grs_reg   <= grs_arr[gnt_idx];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      inflight_valid_reg <= 1'b0;
      inflight_reg       <= '0;
    end else begin
      inflight_valid_reg <= issue;
      if (issue) begin
        inflight_reg.data    <= '0;
        inflight_reg.src     <= SRC_W_MAX'(gnt_idx);
        inflight_reg.tag     <= TAG_W_MAX'(tag_arr[gnt_idx]);
        inflight_reg.inexact <= |grs_arr[gnt_idx];
        inflight_reg.rm_err  <= rm_reserved(rmode_arr[gnt_idx]);
      end
    end
  end

  // The rounding stage result lands exactly one cycle after issue.
  assign push = inflight_valid_reg;

  always_comb begin
    push_entry      = inflight_reg;
    push_entry.data = rnd_data_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fifo_mem[0] <= '0;
      fifo_mem[1] <= '0;
      wr_ptr_reg  <= 1'b0;
      rd_ptr_reg  <= 1'b0;
      occ_reg     <= 2'd0;
    end else begin
      if (push) begin
        fifo_mem[wr_ptr_reg] <= push_entry;
        wr_ptr_reg           <= ~wr_ptr_reg;
      end
      if (pop) begin
        rd_ptr_reg <= ~rd_ptr_reg;
      end
      case ({push, pop})
        2'b10:   occ_reg <= occ_reg + 2'd1;
        2'b01:   occ_reg <= occ_reg - 2'd1;
        default: occ_reg <= occ_reg;
      endcase
    end
  end

  assign rsp_valid_o = (occ_reg != 2'd0);
  assign head        = rsp_valid_o ? fifo_mem[rd_ptr_reg] : '0;

  assign rsp_data_o    = head.data;
  assign rsp_src_o     = head.src[SRC_W-1:0];
  assign rsp_tag_o     = head.tag[TAG_W-1:0];
  assign rsp_inexact_o = head.inexact;
  assign rsp_rm_err_o  = head.rm_err;

  logic unused_head_bits;
  assign unused_head_bits = ^{head.src, head.tag};

endmodule
